// File: rtl/nibble_serial_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nibble_serial_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_adder_slice.sv
// Purely combinational 4-bit ripple-carry adder slice reused once per nibble.
module nibble_adder_slice
    import nibble_serial_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic c;

    always_comb begin
        c = ci;
        s = '0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder that walks one 4-bit slice from LSB to MSB nibble, one per clock.
// Optional subtract mode (a - b) via the NIBBLE_SERIAL_SUB_EN macro, which adds the sub input.
module nibble_serial_add_ctrl
    import nibble_serial_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    generate
        if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_width_check
            $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    // Handshake: start is accepted only in IDLE (busy=0). busy stays high through
    // RUN and DONE; done pulses for the single DONE cycle, when sum/cout/overflow
    // are final. They then hold until the next accepted start.

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [WIDTH-1:0]     b_eff;
    logic                 carry_reg;
    logic                 carry_init;
    logic [IDX_W-1:0]     idx;
    logic                 last_nibble;
    logic [NIBBLE_W-1:0]  slice_a;
    logic [NIBBLE_W-1:0]  slice_b;
    logic [NIBBLE_W-1:0]  slice_s;
    logic                 slice_co;

`ifdef NIBBLE_SERIAL_SUB_EN
    logic sub_reg;

    // Subtraction is a + ~b + 1, so cin is replaced by a forced carry of 1.
    assign b_eff      = sub_reg ? ~b_reg : b_reg;
    assign carry_init = sub ? 1'b1 : cin;
`else
    assign b_eff      = b_reg;
    assign carry_init = cin;
`endif

    assign last_nibble = (idx == LAST_IDX);
    assign slice_a     = a_reg[NIBBLE_W*idx +: NIBBLE_W];
    assign slice_b     = b_eff[NIBBLE_W*idx +: NIBBLE_W];

    nibble_adder_slice u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_reg),
        .s  (slice_s),
        .co (slice_co)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_nibble) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
            sub_reg   <= 1'b0;
`endif
        end else begin
            if ((state == IDLE) && start) begin
                a_reg     <= a;
                b_reg     <= b;
                carry_reg <= carry_init;
                idx       <= '0;
                sum       <= '0;
                cout      <= 1'b0;
                overflow  <= 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
                sub_reg   <= sub;
`endif
            end else if (state == RUN) begin
                sum[NIBBLE_W*idx +: NIBBLE_W] <= slice_s;
                carry_reg                     <= slice_co;
                if (last_nibble) begin
                    cout     <= slice_co;
                    // Signed overflow: like-signed operands yielding a result of the other sign.
                    overflow <= (a_reg[WIDTH-1] == b_eff[WIDTH-1]) &&
                                (slice_s[NIBBLE_W-1] != a_reg[WIDTH-1]);
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16 main instance plus a WIDTH=4 instance).
module tb_nibble_serial_add_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;
    localparam int RW  = W + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          cout;
    logic          overflow;
`ifdef NIBBLE_SERIAL_SUB_EN
    logic          sub;
    logic          sub4;
`endif

    logic          start4;
    logic [3:0]    a4;
    logic [3:0]    b4;
    logic          cin4;
    logic          busy4;
    logic          done4;
    logic [3:0]    sum4;
    logic          cout4;
    logic          overflow4;

    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] mon_e;
    int            errors   = 0;
    int            checks   = 0;
    int            done_cnt = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef NIBBLE_SERIAL_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .start    (start4),
        .a        (a4),
        .b        (b4),
        .cin      (cin4),
`ifdef NIBBLE_SERIAL_SUB_EN
        .sub      (sub4),
`endif
        .busy     (busy4),
        .done     (done4),
        .sum      (sum4),
        .cout     (cout4),
        .overflow (overflow4)
    );

    // Reference: whole-word add, packed as {cout, overflow, sum}.
    function automatic logic [RW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c, input logic s);
        logic [W-1:0] ye;
        logic [W:0]   full;
        logic         ov;
        ye   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, (s ? 1'b1 : c)};
        ov   = (x[W-1] == ye[W-1]) && (full[W-1] != x[W-1]);
        return {full[W], ov, full[W-1:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_sum",  32'(sum),      32'(mon_e[W-1:0]));
                check("sb_cout", 32'(cout),     32'(mon_e[W+1]));
                check("sb_ovf",  32'(overflow), 32'(mon_e[W]));
            end
        end
    end

    // Caller is at a negedge; returns at the first IDLE negedge after done.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input logic s, input bit poke, input string tag);
        int            n;
        int            d0;
        logic [RW-1:0] e;
        e  = model(x, y, c, s);
        d0 = done_cnt;
        a = x; b = y; cin = c; start = 1'b1;
`ifdef NIBBLE_SERIAL_SUB_EN
        sub = s;
`endif
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        check({tag, "_busy_run"}, 32'(busy), 32'd1);
        n = 0;
        while ((done !== 1'b1) && (n < 40)) begin
            @(negedge clk);
            n++;
            start = (poke && (n == 1)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'(NIB));
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_held_sum"}, 32'(sum), 32'(e[W-1:0]));
        check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
        sub = 1'b0; sub4 = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf",  32'(overflow), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, "tp_carry");
        check("tp_carry_sum", 32'(sum), 32'h0100);
        check("tp_carry_co",  32'(cout), 32'd0);
        check("tp_carry_ov",  32'(overflow), 32'd0);

        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "tp_wrap");
        check("tp_wrap_sum", 32'(sum), 32'h0000);
        check("tp_wrap_co",  32'(cout), 32'd1);
        check("tp_wrap_ov",  32'(overflow), 32'd0);

        run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0, "tp_ovf");
        check("tp_ovf_sum", 32'(sum), 32'h8000);
        check("tp_ovf_co",  32'(cout), 32'd0);
        check("tp_ovf_ov",  32'(overflow), 32'd1);

        // A start pulse during RUN must be ignored.
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, "poke");
        check("poke_sum", 32'(sum), 32'h3333);
        run_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0, "back2back");

        // Abort mid-operation with an asynchronous reset.
        a = 16'h00FF; b = 16'h0F01; cin = 1'b0; start = 1'b1;
        exp_q.push_back(model(16'h00FF, 16'h0F01, 1'b0, 1'b0));
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum",  32'(sum),  32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf",  32'(overflow), 32'd0);
        void'(exp_q.pop_back());
        begin
            int d0;
            d0 = done_cnt;
            repeat (3) @(negedge clk);
            reset = 1'b0;
            repeat (3) @(negedge clk);
            check("abort_no_done", 32'(done_cnt - d0), 32'd0);
            check("abort_idle", 32'(busy), 32'd0);
        end
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, "post_abort");
        check("post_abort_sum", 32'(sum), 32'h5555);

        for (int i = 0; i < 4; i++) begin
            run_op(W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)),
                   1'($urandom_range(0, 1)), 1'b0, 1'b0, "rand_add");
        end

`ifdef NIBBLE_SERIAL_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, "sub_neg");
        check("sub_neg_sum", 32'(sum), 32'hFFFE);
        check("sub_neg_co",  32'(cout), 32'd0);
        check("sub_neg_ov",  32'(overflow), 32'd0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, "sub_ovf");
        check("sub_ovf_sum", 32'(sum), 32'h7FFF);
        check("sub_ovf_co",  32'(cout), 32'd1);
        check("sub_ovf_ov",  32'(overflow), 32'd1);
        for (int i = 0; i < 3; i++) begin
            run_op(W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)),
                   1'($urandom_range(0, 1)), 1'b1, 1'b0, "rand_sub");
        end
`endif

        // WIDTH=4 instance: RUN lasts a single cycle.
        a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("w4_busy_run", 32'(busy4), 32'd1);
        check("w4_done_run", 32'(done4), 32'd0);
        @(negedge clk);
        check("w4_done", 32'(done4), 32'd1);
        check("w4_sum",  32'(sum4),  32'h2);
        check("w4_cout", 32'(cout4), 32'd1);
        check("w4_ovf",  32'(overflow4), 32'd1);
        @(negedge clk);
        check("w4_idle", 32'(busy4), 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
